// File: rtl/game_flow_controller.sv
// game_flow_controller: game state FSM with pre-game countdown, pause and game-over handling.
// Define HIGH_SCORE_EN to compile in the best-elapsed-time register.
module game_flow_controller #(
   parameter int CLK_HZ      = 65_000_000,
   parameter int COUNTDOWN_S = 3
) (
   input  logic        system_clock_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic        pause_in,
   input  logic        collision_in,
   input  logic [27:0] elapsed_bcd_in,
   output logic        reset_game_out,
   output logic        playing_out,
   output logic [2:0]  state_out,
   output logic [1:0]  countdown_out,
   output logic [27:0] best_bcd_out
);
   localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAYING   = 3'd2,
      PAUSED    = 3'd3,
      GAME_OVER = 3'd4
   } state_t;
   state_t state_q, state_d;
   logic start_prev_q, pause_prev_q;
   logic [SW-1:0] sec_q, sec_d;
   logic [1:0] cd_q, cd_d;
   logic rg_q, play_q;
   logic start_rise, pause_rise, sec_wrap, entering_cd;
   assign start_rise  = start_in & ~start_prev_q;
   assign pause_rise  = pause_in & ~pause_prev_q;
   assign sec_wrap    = sec_q == SW'(CLK_HZ - 1);
   assign entering_cd = (state_d == COUNTDOWN) && (state_q != COUNTDOWN);
   always_comb begin
      state_d = state_q;
      sec_d   = '0;
      cd_d    = '0;
      case (state_q)
         IDLE:      if (start_rise) state_d = COUNTDOWN;
         COUNTDOWN: begin
            sec_d = sec_wrap ? '0 : sec_q + SW'(1);
            cd_d  = sec_wrap ? cd_q - 2'd1 : cd_q;
            if (sec_wrap && cd_q == 2'd1) state_d = PLAYING;
         end
         PLAYING:   state_d = collision_in ? GAME_OVER : (pause_rise ? PAUSED : PLAYING);
         PAUSED:    if (pause_rise) state_d = PLAYING;
         GAME_OVER: if (start_rise) state_d = COUNTDOWN;
         default:   state_d = IDLE;
      endcase
      if (entering_cd) cd_d = 2'(COUNTDOWN_S);
   end
   // Edge-detect history resets high so a button held through reset is not a press.
   always_ff @(posedge system_clock_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b1;
         pause_prev_q <= 1'b1;
         sec_q        <= '0;
         cd_q         <= '0;
         rg_q         <= 1'b0;
         play_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_in;
         pause_prev_q <= pause_in;
         sec_q        <= sec_d;
         cd_q         <= cd_d;
         rg_q         <= entering_cd;
         play_q       <= state_d == PLAYING;
      end
   end
   assign state_out      = state_q;
   assign countdown_out  = cd_q;
   assign reset_game_out = rg_q;
   assign playing_out    = play_q;
`ifdef HIGH_SCORE_EN
   logic go_first_q;
   logic [27:0] best_q;
   always_ff @(posedge system_clock_in or posedge rst_in) begin
      if (rst_in) begin
         go_first_q <= 1'b0;
         best_q     <= '0;
      end else begin
         go_first_q <= (state_d == GAME_OVER) && (state_q != GAME_OVER);
         best_q     <= (go_first_q && elapsed_bcd_in > best_q) ? elapsed_bcd_in : best_q;
      end
   end
   assign best_bcd_out = best_q;
`else
   logic unused_elapsed;
   assign unused_elapsed = ^elapsed_bcd_in;
   assign best_bcd_out   = '0;
`endif
endmodule
